sdram_fifo_responder: RTL and testbench

- On-chip RAM stand-in for the SDRAM controller side-1 FIFO interface; the target end of the SDRAM interface driven by the memory interface.
- Accepts write requests into a write FIFO, drains them into a block RAM, and serves read requests with fixed latency.
- Used for simulation and for FPGA bring-up without external SDRAM.
- Provides FIFO status flags, an init delay and error flags.

---
 rtl/sdram_fifo_responder_pkg.sv | 20 ++
 rtl/sdram_resp_wfifo.sv | 65 ++++++
 rtl/sdram_fifo_responder.sv | 153 +++++++++++++++
 tb/tb_sdram_fifo_responder.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_fifo_responder_pkg.sv
// Shared definitions for the on-chip SDRAM stand-in: default widths, controller
// state encoding and a counter-width helper.
package sdram_fifo_responder_pkg;

  localparam int DSIZE_DEF     = 16;
  localparam int ASIZE_DEF     = 23;
  localparam int WFIFO_ENTRY_W = ASIZE_DEF + DSIZE_DEF;

  typedef enum logic [1:0] {
    RESP_INIT  = 2'd0,
    RESP_IDLE  = 2'd1,
    RESP_DRAIN = 2'd2
  } resp_state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_resp_wfifo.sv
// Synchronous write FIFO with registered occupancy; head entry is visible on
// dout without a read strobe.
module sdram_resp_wfifo
  import sdram_fifo_responder_pkg::*;
#(
  parameter int WIDTH = WFIFO_ENTRY_W,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = cnt_width(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses <= so every register samples pre-edge values together.
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // NOTE: storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/sdram_fifo_responder.sv
// Target side of the SDRAM FIFO interface: buffers writes, drains them into a
// single-port block RAM and answers reads one cycle later, reads taking priority.
module sdram_fifo_responder
  import sdram_fifo_responder_pkg::*;
#(
  parameter int DSIZE         = DSIZE_DEF,
  parameter int ASIZE         = ASIZE_DEF,
  parameter int MEM_ADDR_BITS = 12,
  parameter int WFIFO_DEPTH   = 8,
  parameter int INIT_CYCLES   = 1000,
  parameter int WRITE_LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DSIZE-1:0] sdram_WR_DATA,
  input  logic             sdram_WR,
  input  logic [ASIZE-1:0] sdram_WR_ADDR,
  input  logic [ASIZE-1:0] sdram_WR_MAX_ADDR,
  output logic             sdram_WR_FULL,
  output logic [15:0]      sdram_WR_USE,
  input  logic             sdram_RD,
  input  logic [ASIZE-1:0] sdram_RD_ADDR,
  output logic [DSIZE-1:0] sdram_RD_DATA,
  output logic             sdram_RD_EMPTY,
  output logic [15:0]      sdram_RD_USE,
  output logic             init_done,
  output logic             overflow_error,
  output logic             range_error
);

  localparam int ENTRY_W = ASIZE + DSIZE;
  localparam int CW      = $clog2(WFIFO_DEPTH) + 1;
  localparam int ICW     = cnt_width(INIT_CYCLES);
  localparam int DCW     = cnt_width(WRITE_LATENCY);
  localparam logic [ICW-1:0] INIT_LAST  = ICW'(INIT_CYCLES - 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(WRITE_LATENCY - 1);

  resp_state_e      state_q;
  logic [ICW-1:0]   init_cnt_q;
  logic [DCW-1:0]   drain_cnt_q;
  logic             init_done_q, wr_prev_q, ovf_q, rng_q, rd_empty_q;
  logic [ASIZE-1:0] last_addr_q;
  logic [DSIZE-1:0] last_data_q, rd_data_q;
  logic [DSIZE-1:0] ram_q [2**MEM_ADDR_BITS];

  logic             push_try, in_range, fifo_push, fifo_pop, rd_fire;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [ENTRY_W-1:0] fifo_dout;
  logic [ASIZE-1:0] head_addr;
  logic [DSIZE-1:0] head_data;
  logic             unused_addr_bits;

  assign rd_fire   = init_done_q && sdram_RD;
  // A held request with an unchanged address/data pair is one transaction.
  assign push_try  = init_done_q && sdram_WR &&
                     (!wr_prev_q || sdram_WR_ADDR != last_addr_q || sdram_WR_DATA != last_data_q);
  assign in_range  = sdram_WR_ADDR < sdram_WR_MAX_ADDR;
  assign fifo_push = push_try && in_range && !fifo_full;
  // The RAM port belongs to the read when both want it; the drain waits a cycle.
  assign fifo_pop  = !reset && state_q == RESP_DRAIN && drain_cnt_q == DRAIN_LAST && !rd_fire;
  assign {head_addr, head_data} = fifo_dout;
  assign unused_addr_bits = ^{sdram_RD_ADDR[ASIZE-1:MEM_ADDR_BITS], head_addr[ASIZE-1:MEM_ADDR_BITS]};

  sdram_resp_wfifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (WFIFO_DEPTH)
  ) u_wfifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({sdram_WR_ADDR, sdram_WR_DATA}),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RESP_INIT;
      init_cnt_q  <= '0;
      drain_cnt_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        RESP_INIT:
          if (init_cnt_q == INIT_LAST) begin
            state_q     <= RESP_IDLE;
            init_done_q <= 1'b1;
          end else begin
            init_cnt_q <= init_cnt_q + 1'b1;
          end
        RESP_IDLE:
          if (!fifo_empty) begin
            state_q     <= RESP_DRAIN;
            drain_cnt_q <= '0;
          end
        RESP_DRAIN:
          if (drain_cnt_q != DRAIN_LAST) begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
          end else if (fifo_pop) begin
            drain_cnt_q <= '0;
            if (fifo_count == CW'(1) && !fifo_push) state_q <= RESP_IDLE;
          end
        default: state_q <= RESP_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_prev_q   <= 1'b0;
      last_addr_q <= '0;
      last_data_q <= '0;
      ovf_q       <= 1'b0;
      rng_q       <= 1'b0;
    end else begin
      wr_prev_q <= init_done_q && sdram_WR;
      if (push_try) begin
        last_addr_q <= sdram_WR_ADDR;
        last_data_q <= sdram_WR_DATA;
      end
      if (push_try && !in_range)              rng_q <= 1'b1;
      if (push_try && in_range && fifo_full)  ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_empty_q <= 1'b1;
    end else begin
      rd_empty_q <= !rd_fire;
      if (rd_fire) rd_data_q <= ram_q[sdram_RD_ADDR[MEM_ADDR_BITS-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_pop) ram_q[head_addr[MEM_ADDR_BITS-1:0]] <= head_data;
  end

  assign sdram_WR_FULL  = !init_done_q || fifo_full;
  assign sdram_WR_USE   = 16'(fifo_count);
  assign sdram_RD_DATA  = rd_data_q;
  assign sdram_RD_EMPTY = rd_empty_q;
  assign sdram_RD_USE   = {15'd0, !rd_empty_q};
  assign init_done      = init_done_q;
  assign overflow_error = ovf_q;
  assign range_error    = rng_q;

endmodule

// File: tb/tb_sdram_fifo_responder.sv
// Bench for sdram_fifo_responder: directed scenarios, a vector table for read
// priority, and randomized traffic compared against a queue-based reference.
module tb_sdram_fifo_responder;

  localparam int MAB         = 12;
  localparam int DEPTH       = 8;
  localparam int INIT_CYCLES = 1000;
  localparam int WL          = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] wr_data = '0;
  logic        wr = 1'b0;
  logic [22:0] wr_addr = '0;
  logic [22:0] wr_max = 23'h7F_FFFF;
  logic        rd = 1'b0;
  logic [22:0] rd_addr = '0;
  logic        wr_full, rd_empty, init_done, ovf, rng;
  logic [15:0] wr_use, rd_use, rd_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sdram_fifo_responder #(
    .DSIZE(16), .ASIZE(23), .MEM_ADDR_BITS(MAB), .WFIFO_DEPTH(DEPTH),
    .INIT_CYCLES(INIT_CYCLES), .WRITE_LATENCY(WL)
  ) dut (
    .clk(clk), .reset(reset),
    .sdram_WR_DATA(wr_data), .sdram_WR(wr), .sdram_WR_ADDR(wr_addr),
    .sdram_WR_MAX_ADDR(wr_max), .sdram_WR_FULL(wr_full), .sdram_WR_USE(wr_use),
    .sdram_RD(rd), .sdram_RD_ADDR(rd_addr), .sdram_RD_DATA(rd_data),
    .sdram_RD_EMPTY(rd_empty), .sdram_RD_USE(rd_use),
    .init_done(init_done), .overflow_error(ovf), .range_error(rng)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending writes in a queue, RAM as an array with known-bits.
  typedef struct {logic [22:0] addr; logic [15:0] data;} entry_t;
  entry_t      m_q[$];
  logic [15:0] m_mem [1<<MAB];
  bit          m_mem_v [1<<MAB];
  int          m_init_left, m_served;
  bit          m_ready, m_busy, m_prev_wr, m_rd_known, m_rd_empty, m_ovf, m_rng;
  logic [22:0] m_last_a;
  logic [15:0] m_last_d, m_rd_data;

  task automatic model_step();
    bit attempt, in_rng, pop, push, start;
    entry_t e;
    if (reset) begin
      m_q.delete();
      m_init_left = INIT_CYCLES;
      m_ready = 0; m_busy = 0; m_served = 0; m_prev_wr = 0;
      m_rd_data = '0; m_rd_known = 1; m_rd_empty = 1; m_ovf = 0; m_rng = 0;
      return;
    end
    if (!m_ready) begin
      m_init_left--;
      if (m_init_left == 0) m_ready = 1;
      m_prev_wr = 0;
      return;
    end
    attempt = wr && (!m_prev_wr || wr_addr != m_last_a || wr_data != m_last_d);
    in_rng  = wr_addr < wr_max;
    pop = 0;
    if (m_busy) begin
      if (m_served < WL - 1) m_served++;
      else if (!rd) pop = 1;
    end
    start = !m_busy && m_q.size() > 0;
    push  = attempt && in_rng && m_q.size() < DEPTH;
    if (attempt && !in_rng) m_rng = 1;
    if (attempt && in_rng && m_q.size() == DEPTH) m_ovf = 1;
    if (attempt) begin m_last_a = wr_addr; m_last_d = wr_data; end
    m_prev_wr = wr;
    if (rd) begin
      m_rd_data  = m_mem[rd_addr[MAB-1:0]];
      m_rd_known = m_mem_v[rd_addr[MAB-1:0]];
      m_rd_empty = 0;
    end else begin
      m_rd_empty = 1;
    end
    if (pop) begin
      e = m_q.pop_front();
      m_mem[e.addr[MAB-1:0]]   = e.data;
      m_mem_v[e.addr[MAB-1:0]] = 1;
    end
    if (push) begin
      e.addr = wr_addr; e.data = wr_data;
      m_q.push_back(e);
    end
    if (pop) begin
      m_served = 0;
      m_busy = m_q.size() > 0;
    end else if (start) begin
      m_busy = 1; m_served = 0;
    end
  endtask

  task automatic compare_model();
    check("model.wr_full", wr_full, !m_ready || m_q.size() == DEPTH);
    check("model.wr_use", wr_use, m_q.size());
    check("model.rd_empty", rd_empty, m_rd_empty);
    check("model.rd_use", rd_use, !m_rd_empty);
    if (m_rd_known) check("model.rd_data", rd_data, m_rd_data);
    check("model.init_done", init_done, m_ready);
    check("model.overflow_error", ovf, m_ovf);
    check("model.range_error", rng, m_rng);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic write_one(input logic [22:0] a, input logic [15:0] d);
    wr = 1; wr_addr = a; wr_data = d;
    tick();
    wr = 0;
    tick();
  endtask

  task automatic read_check(input string name, input logic [22:0] a, input logic [15:0] exp);
    rd = 1; rd_addr = a;
    tick();
    check({name, ".data"}, rd_data, exp);
    check({name, ".empty"}, rd_empty, 0);
    check({name, ".use"}, rd_use, 1);
    rd = 0;
  endtask

  task automatic wait_drained(input int budget);
    int n;
    wr = 0; rd = 0; n = 0;
    while (wr_use != 16'd0 && n < budget) begin
      tick();
      n++;
    end
    n_checks++;
    if (n >= budget) begin
      n_errors++;
      $display("FAIL drain_timeout: wr_use=%0d after %0d cycles, required 0", wr_use, n);
    end
    repeat (2) tick();
  endtask

  typedef struct {
    logic        wr;
    logic [22:0] wa;
    logic [15:0] wd;
    logic        rd;
    logic [22:0] ra;
    logic [15:0] exp_use;
    logic        exp_empty;
    logic [15:0] exp_data;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [22:0] wa, input logic [15:0] wd,
                              input logic r, input logic [22:0] ra, input logic [15:0] eu,
                              input logic ee, input logic [15:0] ed);
    vec_t v;
    v.wr = w; v.wa = wa; v.wd = wd; v.rd = r; v.ra = ra;
    v.exp_use = eu; v.exp_empty = ee; v.exp_data = ed;
    return v;
  endfunction

  initial begin
    vec_t        vecs[15];
    int          rises, peak;
    logic [15:0] prev_use;

    // Read-priority sequence: a queued write to 0x20 waits out three reads of 0x10.
    vecs[0] = mk(0, 23'h0, 16'h0, 1, 23'h11, 16'd0, 0, 16'hDEAD);
    vecs[1] = mk(1, 23'h20, 16'h7777, 0, 23'h0, 16'd1, 1, 16'hDEAD);
    for (int i = 2; i <= 9; i++) vecs[i] = mk(0, 23'h0, 16'h0, 0, 23'h0, 16'd1, 1, 16'hDEAD);
    for (int i = 10; i <= 12; i++) vecs[i] = mk(0, 23'h0, 16'h0, 1, 23'h10, 16'd1, 0, 16'hBEEF);
    vecs[13] = mk(0, 23'h0, 16'h0, 0, 23'h0, 16'd0, 1, 16'hBEEF);
    vecs[14] = mk(0, 23'h0, 16'h0, 1, 23'h20, 16'd0, 0, 16'h7777);

    // Reset values
    reset = 1;
    repeat (3) tick();
    check("reset.wr_full", wr_full, 1);
    check("reset.wr_use", wr_use, 0);
    check("reset.rd_data", rd_data, 0);
    check("reset.rd_empty", rd_empty, 1);
    check("reset.rd_use", rd_use, 0);
    check("reset.init_done", init_done, 0);
    check("reset.overflow_error", ovf, 0);
    check("reset.range_error", rng, 0);

    // Init delay, with a write pulse in the middle that must be ignored
    reset = 0;
    for (int k = 1; k <= INIT_CYCLES; k++) begin
      wr = (k == 500); wr_addr = 23'h30; wr_data = 16'h1111;
      tick();
      if (k < INIT_CYCLES) begin
        check("init.done_low", init_done, 0);
        check("init.full_high", wr_full, 1);
      end
    end
    wr = 0;
    check("init.done", init_done, 1);
    check("init.full_released", wr_full, 0);
    check("init.ignored_write", wr_use, 0);

    // Duplicate suppression
    wr = 1; wr_addr = 23'h10; wr_data = 16'hBEEF;
    rises = 0; prev_use = wr_use;
    for (int k = 0; k < 140; k++) begin
      if (k == 70) begin wr_addr = 23'h11; wr_data = 16'hDEAD; end
      tick();
      if (wr_use > prev_use) rises++;
      prev_use = wr_use;
    end
    wr = 0;
    check("dup.push_count", rises, 2);
    wait_drained(100);
    read_check("dup.rd10", 23'h10, 16'hBEEF);
    read_check("dup.rd11", 23'h11, 16'hDEAD);
    tick();
    check("rd.idle_empty", rd_empty, 1);
    check("rd.idle_hold", rd_data, 16'hDEAD);
    check("rd.idle_use", rd_use, 0);

    // Vector table
    for (int i = 0; i < 15; i++) begin
      wr = vecs[i].wr; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      rd = vecs[i].rd; rd_addr = vecs[i].ra;
      tick();
      check($sformatf("vec%0d.wr_use", i), wr_use, vecs[i].exp_use);
      check($sformatf("vec%0d.rd_empty", i), rd_empty, vecs[i].exp_empty);
      check($sformatf("vec%0d.rd_use", i), rd_use, !vecs[i].exp_empty);
      check($sformatf("vec%0d.rd_data", i), rd_data, vecs[i].exp_data);
    end
    wr = 0; rd = 0;

    // Range limit
    write_one(23'h100, 16'h5555);
    write_one(23'h8, 16'h0808);
    write_one(23'h9, 16'h0909);
    wait_drained(100);
    check("range.pre", rng, 0);
    wr_max = 23'h100;
    wr = 1; wr_addr = 23'h100; wr_data = 16'h1234;
    tick();
    wr = 0;
    check("range.flag", rng, 1);
    check("range.use", wr_use, 0);
    repeat (12) tick();
    check("range.use_later", wr_use, 0);
    read_check("range.ram_kept", 23'h100, 16'h5555);
    check("range.no_overflow", ovf, 0);
    wr_max = 23'h7F_FFFF;

    // Overflow
    peak = 0;
    for (int i = 0; i < 10; i++) begin
      wr = 1; wr_addr = 23'(i); wr_data = 16'hA000 + 16'(i);
      tick();
      if (int'(wr_use) > peak) peak = int'(wr_use);
      if (i == 7) begin
        check("ovf.full_at_8", wr_full, 1);
        check("ovf.not_yet", ovf, 0);
      end
      if (i == 8) check("ovf.flag", ovf, 1);
    end
    wr = 0;
    check("ovf.peak_use", peak, 8);
    wait_drained(200);
    for (int i = 0; i < 8; i++) read_check($sformatf("ovf.rd%0d", i), 23'(i), 16'hA000 + 16'(i));
    read_check("ovf.dropped8", 23'h8, 16'h0808);
    read_check("ovf.dropped9", 23'h9, 16'h0909);

    // Address aliasing
    write_one(23'h1005, 16'hC0DE);
    wait_drained(100);
    read_check("alias.rd005", 23'h005, 16'hC0DE);

    // Randomized traffic against the model
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 3) != 0) begin
        wr = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 2) == 0) begin
          wr_addr = {($urandom_range(0, 1) != 0) ? 11'h2 : 11'h0, 12'($urandom_range(0, 31))};
          wr_data = 16'($urandom);
        end
      end
      rd = ($urandom_range(0, 3) == 0);
      rd_addr = {($urandom_range(0, 1) != 0) ? 11'h3 : 11'h0, 12'($urandom_range(0, 31))};
      wr_max = ($urandom_range(0, 15) == 0) ? 23'h18 : 23'h7F_FFFF;
      tick();
    end
    wr_max = 23'h7F_FFFF;
    wait_drained(200);

    // Reset with entries pending
    wr = 1;
    for (int i = 0; i < 3; i++) begin
      wr_addr = 23'h40 + 23'(i); wr_data = 16'h4000 + 16'(i);
      tick();
    end
    wr = 0;
    check("rst.pending", wr_use, 3);
    reset = 1;
    tick();
    check("rst.use", wr_use, 0);
    check("rst.full", wr_full, 1);
    check("rst.init_done", init_done, 0);
    reset = 0;
    repeat (5) tick();
    check("rst.reinit", init_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
